// File: rtl/tick_timer_pkg.sv
// Shared encodings for the tick-driven timer: FSM state and reload mode.
// Imported by tick_timer; no logic lives here.
package tick_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_timer.sv
// Counts tick enables down from a loaded value and pulses expired one cycle after the terminal tick.
// start is honoured only in IDLE; abort always wins and returns to IDLE silently.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] load,
  input  logic             periodic,
  input  logic             abort,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             mode_q, mode_nxt;
  logic             expired_q, expired_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      expired_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_q   <= count_nxt;
      reload_q  <= reload_nxt;
      mode_q    <= mode_nxt;
      expired_q <= expired_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count_q;
    reload_nxt  = reload_q;
    mode_nxt    = mode_q;
    expired_nxt = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          // A tick arriving with start is deliberately not counted.
          if (start) begin
            reload_nxt = load;
            mode_nxt   = periodic;
            if (load != '0) begin
              count_nxt = load;
              state_nxt = RUN;
            end else begin
              expired_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (count_q > ONE) begin
              count_nxt = count_q - ONE;
            end else begin
              expired_nxt = 1'b1;
              if (mode_q == MODE_PERIODIC) begin
                count_nxt = reload_q;
              end else begin
                count_nxt = '0;
                state_nxt = IDLE;
              end
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign expired = expired_q;
  assign count   = count_q;

endmodule
